regwrite_scheduler: RTL and testbench

Write-back sequencer for the register file's destination-select mux and write enable in the multicycle CPU. It accepts a decoded instruction and waits for the execute stage to finish. It then drives the 3-bit RegDst selector and a single-cycle reg_write pulse, or suppresses the write on overflow, no-write instructions, illegal opcodes or execute timeout. It sits between the main control FSM (issue side) and the ALU/mult-div execute path (completion side).

---
 rtl/regwrite_scheduler_if.sv | 26 ++
 rtl/regwrite_scheduler.sv | 142 ++++++++++++++
 tb/tb_regwrite_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regwrite_scheduler_if.sv
// Issue/completion handshake and write-back control bundle for regwrite_scheduler.
// The master side is the control FSM plus execute path; the slave side is the scheduler.
interface regwrite_scheduler_if;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       exec_done;
  logic       ovf;
  logic [2:0] reg_dst_sel;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       exc_ovf;
  logic       exc_illegal;
  logic       exc_timeout;

  modport master (
    output start, opcode, funct, exec_done, ovf,
    input  reg_dst_sel, reg_write, busy, done, exc_ovf, exc_illegal, exc_timeout
  );

  modport slave (
    input  start, opcode, funct, exec_done, ovf,
    output reg_dst_sel, reg_write, busy, done, exc_ovf, exc_illegal, exc_timeout
  );
endinterface

// File: rtl/regwrite_scheduler.sv
// Write-back sequencer: decodes an issued instruction, waits for execute completion,
// then drives RegDst and a single reg_write pulse or reports why the write was dropped.
module regwrite_scheduler #(
  parameter int MAX_WAIT = 64
) (
  input logic             clk,
  input logic             reset,
  regwrite_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_EXEC, WRITE, FINISH} state_t;

  state_t     state, stateNext;
  logic [7:0] waitCnt, waitCntNext;
  logic [2:0] sel, selNext;
  logic       chkOvf, chkOvfNext;

  logic       decWrite, decChk, decIllegal;
  logic [2:0] decSel;

  logic [2:0] dstSelNext;
  logic       busyNext, doneNext, regWriteNext;
  logic       excOvfNext, excIllegalNext, excTimeoutNext;

  // Instruction class decode, only consumed in IDLE when start is accepted
  always_comb begin
    decWrite   = 1'b0;
    decChk     = 1'b0;
    decIllegal = 1'b0;
    decSel     = 3'b000;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h08, 6'h18, 6'h1A, 6'h0D, 6'h13: decWrite = 1'b0;
          default: begin
            decWrite = 1'b1;
            decSel   = 3'b001;
            decChk   = (bus.funct == 6'h20) || (bus.funct == 6'h22);
          end
        endcase
      end
      6'h08: begin
        decWrite = 1'b1;
        decChk   = 1'b1;
      end
      6'h09, 6'h0A, 6'h0F, 6'h20, 6'h23: decWrite = 1'b1;
      6'h03: begin
        decWrite = 1'b1;
        decSel   = 3'b010;
      end
      6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h2B: decWrite = 1'b0;
      default: decIllegal = 1'b1;
    endcase
  end

  // Next-state logic; outputs are derived from the next state so they can be registered
  always_comb begin
    stateNext      = state;
    waitCntNext    = waitCnt;
    selNext        = sel;
    chkOvfNext     = chkOvf;
    excOvfNext     = 1'b0;
    excIllegalNext = 1'b0;
    excTimeoutNext = 1'b0;
    case (state)
      IDLE: begin
        selNext    = 3'b000;
        chkOvfNext = 1'b0;
        if (bus.start) begin
          selNext     = decSel;
          chkOvfNext  = decChk;
          waitCntNext = 8'd0;
          if (decIllegal) begin
            stateNext      = FINISH;
            excIllegalNext = 1'b1;
          end else if (decWrite) begin
            stateNext = WAIT_EXEC;
          end else begin
            stateNext = FINISH;
          end
        end
      end
      WAIT_EXEC: begin
        if (bus.exec_done) begin
          if (chkOvf && bus.ovf) begin
            stateNext  = FINISH;
            excOvfNext = 1'b1;
          end else begin
            stateNext = WRITE;
          end
        end else if (waitCnt == 8'(MAX_WAIT - 1)) begin
          stateNext      = FINISH;
          excTimeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + 8'd1;
        end
      end
      WRITE: stateNext = FINISH;
      FINISH: begin
        stateNext  = IDLE;
        selNext    = 3'b000;
        chkOvfNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase

    busyNext     = (stateNext != IDLE);
    regWriteNext = (stateNext == WRITE);
    doneNext     = (stateNext == FINISH);
    dstSelNext   = (stateNext == IDLE) ? 3'b000 : selNext;
  end

  // State and registered Moore outputs; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      waitCnt         <= 8'd0;
      sel             <= 3'b000;
      chkOvf          <= 1'b0;
      bus.reg_dst_sel <= 3'b000;
      bus.reg_write   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.exc_ovf     <= 1'b0;
      bus.exc_illegal <= 1'b0;
      bus.exc_timeout <= 1'b0;
    end else begin
      state           <= stateNext;
      waitCnt         <= waitCntNext;
      sel             <= selNext;
      chkOvf          <= chkOvfNext;
      bus.reg_dst_sel <= dstSelNext;
      bus.reg_write   <= regWriteNext;
      bus.busy        <= busyNext;
      bus.done        <= doneNext;
      bus.exc_ovf     <= excOvfNext;
      bus.exc_illegal <= excIllegalNext;
      bus.exc_timeout <= excTimeoutNext;
    end
  end

endmodule

// File: tb/tb_regwrite_scheduler.sv
// Self-checking bench for regwrite_scheduler: directed vector table, reset-abort
// sequence and randomized transactions scored against a transaction-level model.
module tb_regwrite_scheduler;

  localparam int MAX_WAIT = 4;
  localparam int EXC_NONE = 0, EXC_OVF = 1, EXC_ILL = 2, EXC_TMO = 3;

  logic clk;
  logic reset;
  int   vecCount  = 0;
  int   missCount = 0;

  regwrite_scheduler_if bus ();

  regwrite_scheduler #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         execAt;
    bit         ovf;
    bit         noise;
    logic [2:0] sel;
    int         wrCyc;
    int         doneCyc;
    int         exc;
  } vec_t;

  vec_t vecs[16];

  // Output vector packed as {sel, reg_write, busy, done, exc_ovf, exc_illegal, exc_timeout}
  task automatic checkOutput(input string name, input bit eBusy, input logic [2:0] eSel,
                             input bit eWr, input bit eDone, input bit eEo,
                             input bit eEi, input bit eEt);
    logic [8:0] act, expv;
    act  = {bus.reg_dst_sel, bus.reg_write, bus.busy, bus.done,
            bus.exc_ovf, bus.exc_illegal, bus.exc_timeout};
    expv = {eSel, eWr, eBusy, eDone, eEo, eEi, eEt};
    vecCount++;
    if (act !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got sel/wr/busy/done/eo/ei/et=%b required %b", name, act, expv);
    end
  endtask

  task automatic driveIdle();
    bus.start     = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.exec_done = 1'b0;
    bus.ovf       = 1'b0;
  endtask

  // Issues one instruction at the current cycle and checks every cycle until IDLE
  task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn,
                               input int execAt, input bit ovfv, input bit noise,
                               input logic [2:0] eSel, input int eWr, input int eDone,
                               input int eExc);
    int endCyc;
    endCyc        = eDone + 1;
    bus.start     = 1'b1;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.exec_done = noise;
    bus.ovf       = 1'($urandom_range(0, 1));
    for (int n = 1; n <= endCyc; n++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s c%0d", name, n), n < endCyc, (n < endCyc) ? eSel : 3'b000,
                  n == eWr, n == eDone, (eExc == EXC_OVF) && (n == eDone),
                  (eExc == EXC_ILL) && (n == eDone), (eExc == EXC_TMO) && (n == eDone));
      if (n < endCyc) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.opcode    = 6'($urandom);
        bus.funct     = 6'($urandom);
        bus.exec_done = (n == execAt);
        bus.ovf       = (n == execAt) ? ovfv : 1'($urandom_range(0, 1));
      end else begin
        driveIdle();
      end
    end
  endtask

  // Reference decode straight from the instruction-class lists
  task automatic modelDecode(input logic [5:0] op, input logic [5:0] fn,
                             output int cls, output logic [2:0] s, output bit chk);
    cls = 2;
    s   = 3'b000;
    chk = 1'b0;
    if (op == 6'h00) begin
      if (fn inside {6'h08, 6'h18, 6'h1A, 6'h0D, 6'h13}) cls = 1;
      else begin
        s   = 3'b001;
        chk = fn inside {6'h20, 6'h22};
      end
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0F, 6'h20, 6'h23}) begin
      chk = (op == 6'h08);
    end else if (op == 6'h03) begin
      s = 3'b010;
    end else if (op inside {6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h2B}) begin
      cls = 1;
    end else begin
      cls = 0;
    end
  endtask

  task automatic runRandom(input int idx);
    logic [5:0] op, fn;
    logic [5:0] opPool[16];
    logic [5:0] fnPool[8];
    int         cls, execAt, wr, dn, exc;
    logic [2:0] s;
    bit         chk, ovfv;
    opPool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0F, 6'h20,
               6'h23, 6'h03, 6'h02, 6'h04, 6'h2B, 6'h28, 6'h3F, 6'h11};
    fnPool = '{6'h20, 6'h22, 6'h21, 6'h08, 6'h18, 6'h1A, 6'h0D, 6'h13};
    op     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opPool[$urandom_range(0, 15)];
    fn     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnPool[$urandom_range(0, 7)];
    execAt = $urandom_range(0, MAX_WAIT + 1);
    ovfv   = 1'($urandom_range(0, 1));
    modelDecode(op, fn, cls, s, chk);
    wr  = 0;
    exc = EXC_NONE;
    if (cls == 0) begin
      dn  = 1;
      exc = EXC_ILL;
    end else if (cls == 1) begin
      dn = 1;
    end else if (execAt < 1 || execAt > MAX_WAIT) begin
      dn  = MAX_WAIT + 1;
      exc = EXC_TMO;
    end else if (chk && ovfv) begin
      dn  = execAt + 1;
      exc = EXC_OVF;
    end else begin
      wr = execAt + 1;
      dn = execAt + 2;
    end
    applyStimulus($sformatf("rand%0d op%02h fn%02h", idx, op, fn), op, fn, execAt, ovfv,
                  1'($urandom_range(0, 1)), s, wr, dn, exc);
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 3, 1'b0, 1'b0, 3'b001, 4, 5, EXC_NONE};
    vecs[1]  = '{6'h03, 6'h15, 1, 1'b0, 1'b0, 3'b010, 2, 3, EXC_NONE};
    vecs[2]  = '{6'h08, 6'h00, 2, 1'b1, 1'b0, 3'b000, 0, 3, EXC_OVF};
    vecs[3]  = '{6'h09, 6'h00, 2, 1'b1, 1'b0, 3'b000, 3, 4, EXC_NONE};
    vecs[4]  = '{6'h2B, 6'h00, 0, 1'b0, 1'b0, 3'b000, 0, 1, EXC_NONE};
    vecs[5]  = '{6'h3F, 6'h00, 1, 1'b0, 1'b0, 3'b000, 0, 1, EXC_ILL};
    vecs[6]  = '{6'h23, 6'h00, 0, 1'b0, 1'b1, 3'b000, 0, 5, EXC_TMO};
    vecs[7]  = '{6'h23, 6'h00, 4, 1'b0, 1'b0, 3'b000, 5, 6, EXC_NONE};
    vecs[8]  = '{6'h00, 6'h22, 1, 1'b1, 1'b0, 3'b001, 0, 2, EXC_OVF};
    vecs[9]  = '{6'h00, 6'h21, 1, 1'b1, 1'b0, 3'b001, 2, 3, EXC_NONE};
    vecs[10] = '{6'h00, 6'h08, 1, 1'b0, 1'b0, 3'b000, 0, 1, EXC_NONE};
    vecs[11] = '{6'h00, 6'h18, 0, 1'b0, 1'b0, 3'b000, 0, 1, EXC_NONE};
    vecs[12] = '{6'h04, 6'h00, 0, 1'b0, 1'b0, 3'b000, 0, 1, EXC_NONE};
    vecs[13] = '{6'h0F, 6'h00, 1, 1'b0, 1'b1, 3'b000, 2, 3, EXC_NONE};
    vecs[14] = '{6'h08, 6'h00, 5, 1'b1, 1'b0, 3'b000, 0, 5, EXC_TMO};
    vecs[15] = '{6'h00, 6'h20, 2, 1'b1, 1'b0, 3'b001, 0, 3, EXC_OVF};

    reset = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("in reset", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after reset", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].execAt,
                    vecs[i].ovf, vecs[i].noise, vecs[i].sel, vecs[i].wrCyc,
                    vecs[i].doneCyc, vecs[i].exc);
    end

    $display("[TB] reset during WAIT_EXEC");
    bus.start  = 1'b1;
    bus.opcode = 6'h23;
    bus.funct  = 6'h00;
    @(posedge clk);
    #1;
    checkOutput("abort wait1", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start  = 1'b0;
    bus.opcode = 6'h00;
    @(posedge clk);
    #1;
    checkOutput("abort wait2", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort async", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.exec_done = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      bus.exec_done = 1'b0;
      checkOutput($sformatf("abort hold%0d", n), 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort release", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("post-abort add", 6'h00, 6'h20, 2, 1'b0, 1'b0, 3'b001, 3, 4, EXC_NONE);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 60; i++) runRandom(i);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
